snow64_sliced_data_assembler: RTL and testbench

- Builds one 64-bit packed vector from a serial stream of scalar elements.
- Element widths are 8, 16, 32 or 64 bits; the output word uses the standard sliced layout (SlicedData8/16/32/64).
- Element 0 lands in data_0, which is the LSBs.
- Used on vector writeback and load paths wherever per-lane scalar results must be regrouped into a sliced vector word.

---
 rtl/snow64_sliced_data_assembler.sv | 139 +++++++++++++
 tb/tb_snow64_sliced_data_assembler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_sliced_data_assembler.sv
// Serial-to-sliced vector assembler: collects 8/16/32/64-bit scalar elements
// one at a time and packs them into a 64-bit sliced vector word, element 0
// in the LSBs. Each byte of the output is owned by a byte-lane instance.

// One output byte: decides which element (and which byte of it) lands here
// for the current lane size, and holds the assembled value.
module snow64_sda_byte_lane #(
  parameter int BYTE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        acc,
  input  logic [1:0]  size,
  input  logic [2:0]  idx,
  input  logic [63:0] elem,
  output logic [7:0]  q
);
  logic [2:0] owner;
  logic [2:0] off;
  logic       we;

  // Element index that owns this byte, and the byte offset within it.
  always_comb begin
    owner = 3'(BYTE >> size);
    off   = 3'(BYTE & ((1 << size) - 1));
    we    = acc & (idx == owner);
  end

  // Byte storage: cleared on start/flush, written when its element arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= elem[{off, 3'b000} +: 8];
  end
endmodule

module snow64_sliced_data_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_start,
  input  logic [1:0]  in_size,
  input  logic        in_flush,
  input  logic        in_elem_valid,
  input  logic [63:0] in_elem_data,
  output logic        out_elem_ready,
  output logic        out_vec_valid,
  input  logic        in_vec_ready,
  output logic [63:0] out_vec_data,
  output logic [1:0]  out_vec_size,
  output logic        out_busy
);
  localparam int NUM_LANES = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]                  state;
  logic [2:0]                  idx;
  logic [1:0]                  size_q;
  logic [2:0]                  last_idx;
  logic                        elem_acc;
  logic                        start_acc;
  logic                        clr;
  logic [NUM_LANES-1:0][7:0]   lane_q;

  // Handshake decode; flush gates every other action in the same cycle.
  always_comb begin
    last_idx  = 3'((4'd8 >> size_q) - 4'd1);
    elem_acc  = ~in_flush & (state == ST_FILL) & in_elem_valid;
    start_acc = ~in_flush & in_start &
                ((state == ST_IDLE) | ((state == ST_EMIT) & in_vec_ready));
    clr       = in_flush | start_acc;
  end

  // Control FSM: lane index, latched size and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      size_q <= '0;
    end else if (in_flush) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_acc) begin
          size_q <= in_size;
          idx    <= '0;
          state  <= ST_FILL;
        end
        ST_FILL: if (elem_acc) begin
          if (idx == last_idx) begin
            idx   <= '0;
            state <= ST_EMIT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_EMIT: if (in_vec_ready) begin
          if (start_acc) begin
            size_q <= in_size;
            idx    <= '0;
            state  <= ST_FILL;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      snow64_sda_byte_lane #(.BYTE(g)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .acc  (elem_acc),
        .size (size_q),
        .idx  (idx),
        .elem (in_elem_data),
        .q    (lane_q[g])
      );
    end
  endgenerate

  // Outputs are pure decodes of registered state.
  always_comb begin
    out_elem_ready = (state == ST_FILL);
    out_vec_valid  = (state == ST_EMIT);
    out_busy       = (state != ST_IDLE);
    out_vec_data   = lane_q;
    out_vec_size   = size_q;
  end
endmodule

// File: tb/tb_snow64_sliced_data_assembler.sv
// Bench for snow64_sliced_data_assembler: directed table, hand sequences for
// backpressure / back-to-back / flush / async reset, and random vectors
// checked against an arithmetic packing model.
module tb_snow64_sliced_data_assembler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_flush = 1'b0;
  logic        in_elem_valid = 1'b0;
  logic [63:0] in_elem_data = '0;
  logic        out_elem_ready;
  logic        out_vec_valid;
  logic        in_vec_ready = 1'b0;
  logic [63:0] out_vec_data;
  logic [1:0]  out_vec_size;
  logic        out_busy;

  int n_cmp = 0;
  int n_err = 0;

  snow64_sliced_data_assembler dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_size(in_size),
    .in_flush(in_flush), .in_elem_valid(in_elem_valid), .in_elem_data(in_elem_data),
    .out_elem_ready(out_elem_ready), .out_vec_valid(out_vec_valid),
    .in_vec_ready(in_vec_ready), .out_vec_data(out_vec_data),
    .out_vec_size(out_vec_size), .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        size;
    logic [7:0][63:0]  elems;
    logic [63:0]       exp;
    logic [3:0]        gap;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: element i occupies bits [i*W +: W], W = 8<<size.
  function automatic logic [63:0] model(input logic [1:0] sz, input logic [7:0][63:0] el);
    int w = 8 << sz;
    int n = 8 >> sz;
    logic [63:0] mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = r | ((el[i] & mask) << (i * w));
    return r;
  endfunction

  task automatic start_vec(input logic [1:0] sz);
    in_start = 1'b1; in_size = sz;
    step();
    in_start = 1'b0; in_size = 2'(~sz);
    chk("fill_ready", {63'd0, out_elem_ready}, 64'd1);
  endtask

  task automatic feed(input logic [1:0] sz, input logic [7:0][63:0] el, input int gap_max);
    for (int i = 0; i < (8 >> sz); i++) begin
      int gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < gaps; k++) begin
        in_elem_valid = 1'b0; in_elem_data = {$urandom, $urandom};
        in_start = 1'b1;  // ignored while filling
        step();
        in_start = 1'b0;
        chk("gap_ready", {63'd0, out_elem_ready}, 64'd1);
      end
      in_elem_valid = 1'b1; in_elem_data = el[i];
      step();
      in_elem_valid = 1'b0;
    end
  endtask

  task automatic check_emit(input logic [1:0] sz, input logic [63:0] exp);
    chk("emit_valid", {63'd0, out_vec_valid}, 64'd1);
    chk("emit_no_ready", {63'd0, out_elem_ready}, 64'd0);
    chk("emit_data", out_vec_data, exp);
    chk("emit_size", {62'd0, out_vec_size}, {62'd0, sz});
  endtask

  task automatic deliver(input int stall, input logic [63:0] exp);
    for (int k = 0; k < stall; k++) begin
      step();
      chk("stall_valid", {63'd0, out_vec_valid}, 64'd1);
      chk("stall_data", out_vec_data, exp);
      chk("stall_no_ready", {63'd0, out_elem_ready}, 64'd0);
    end
    in_vec_ready = 1'b1;
    step();
    in_vec_ready = 1'b0;
    chk("idle_busy", {63'd0, out_busy}, 64'd0);
    chk("idle_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("idle_hold_data", out_vec_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [3];
    logic [7:0][63:0] el;
    logic [63:0] exp;

    tbl[0].size = 2'd0; tbl[0].gap = 4'd0; tbl[0].exp = 64'h8877_6655_4433_2211;
    for (int i = 0; i < 8; i++) tbl[0].elems[i] = 64'hFFFF_FFFF_FFFF_FF00 | 64'(8'h11 * (i + 1));
    tbl[1].size = 2'd1; tbl[1].gap = 4'd3; tbl[1].exp = 64'hDDDD_CCCC_BBBB_AAAA;
    tbl[1].elems = '0;
    tbl[1].elems[0] = 64'h1234_5678_9ABC_AAAA; tbl[1].elems[1] = 64'hFFFF_FFFF_FFFF_BBBB;
    tbl[1].elems[2] = 64'h0000_0001_0000_CCCC; tbl[1].elems[3] = 64'h8000_0000_0000_DDDD;
    tbl[2].size = 2'd3; tbl[2].gap = 4'd2; tbl[2].exp = 64'hCAFE_F00D_0BAD_BEEF;
    tbl[2].elems = '0; tbl[2].elems[0] = 64'hCAFE_F00D_0BAD_BEEF;

    // Reset state
    #3;
    chk("rst_ready", {63'd0, out_elem_ready}, 64'd0);
    chk("rst_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("rst_busy", {63'd0, out_busy}, 64'd0);
    chk("rst_data", out_vec_data, 64'd0);
    chk("rst_size", {62'd0, out_vec_size}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed table
    for (int t = 0; t < 3; t++) begin
      start_vec(tbl[t].size);
      feed(tbl[t].size, tbl[t].elems, int'(tbl[t].gap));
      check_emit(tbl[t].size, tbl[t].exp);
      deliver(t, tbl[t].exp);
    end

    // Output backpressure, 32-bit
    el = '0; el[0] = 64'hAAAA_AAAA_1234_5678; el[1] = 64'h5555_5555_9ABC_DEF0;
    start_vec(2'd2);
    feed(2'd2, el, 0);
    check_emit(2'd2, 64'h9ABC_DEF0_1234_5678);
    deliver(5, 64'h9ABC_DEF0_1234_5678);

    // Back-to-back: 64-bit vector, then immediate 8-bit start on handshake
    el = '0; el[0] = 64'hDEAD_BEEF_0123_4567;
    start_vec(2'd3);
    feed(2'd3, el, 0);
    check_emit(2'd3, 64'hDEAD_BEEF_0123_4567);
    in_vec_ready = 1'b1; in_start = 1'b1; in_size = 2'd0;
    step();
    in_vec_ready = 1'b0; in_start = 1'b0;
    chk("b2b_busy", {63'd0, out_busy}, 64'd1);
    chk("b2b_ready", {63'd0, out_elem_ready}, 64'd1);
    chk("b2b_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("b2b_data", out_vec_data, 64'd0);
    chk("b2b_size", {62'd0, out_vec_size}, 64'd0);
    for (int i = 0; i < 8; i++) el[i] = {$urandom, $urandom};
    exp = model(2'd0, el);
    feed(2'd0, el, 1);
    check_emit(2'd0, exp);
    deliver(0, exp);

    // Flush mid-fill with a simultaneous element
    for (int i = 0; i < 8; i++) el[i] = 64'(8'hA0 + i);
    start_vec(2'd0);
    for (int i = 0; i < 3; i++) begin
      in_elem_valid = 1'b1; in_elem_data = el[i]; step();
    end
    in_flush = 1'b1; in_elem_data = 64'hEE;
    step();
    in_flush = 1'b0; in_elem_valid = 1'b0;
    chk("flush_busy", {63'd0, out_busy}, 64'd0);
    chk("flush_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("flush_data", out_vec_data, 64'd0);
    for (int i = 0; i < 8; i++) el[i] = 64'(8'h01 << (i % 8)) | 64'hFF00;
    exp = model(2'd0, el);
    start_vec(2'd0);
    feed(2'd0, el, 0);
    check_emit(2'd0, exp);
    deliver(0, exp);

    // Flush in EMIT together with ready and start: nothing delivered, no restart
    el = '0; el[0] = 64'h1111; el[1] = 64'h2222;
    start_vec(2'd2);
    feed(2'd2, el, 0);
    in_flush = 1'b1; in_vec_ready = 1'b1; in_start = 1'b1; in_size = 2'd1;
    step();
    in_flush = 1'b0; in_vec_ready = 1'b0; in_start = 1'b0;
    chk("eflush_busy", {63'd0, out_busy}, 64'd0);
    chk("eflush_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("eflush_data", out_vec_data, 64'd0);

    // Async reset mid-EMIT
    el = '0; el[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    start_vec(2'd3);
    feed(2'd3, el, 0);
    check_emit(2'd3, 64'h0F0F_0F0F_0F0F_0F0F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_vec_valid}, 64'd0);
    chk("arst_busy", {63'd0, out_busy}, 64'd0);
    chk("arst_data", out_vec_data, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Random vectors against the packing model
    for (int r = 0; r < 40; r++) begin
      logic [1:0] sz = 2'($urandom_range(3, 0));
      for (int i = 0; i < 8; i++) el[i] = {$urandom, $urandom};
      exp = model(sz, el);
      start_vec(sz);
      feed(sz, el, 2);
      check_emit(sz, exp);
      deliver(int'($urandom_range(3, 0)), exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
